// File: rtl/instruction_encoder_if.sv
// Command-in / FIFO-write-out bundle for the instruction encoder.
// The master side drives commands and FIFO status; the slave side packs and writes words.
interface instruction_encoder_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        inst_type;
   logic        vertice_num;
   logic [47:0] coordinates;
   logic        layer_num;
   logic        fill_type;
   logic [23:0] color_code;
   logic [1:0]  texture_code;
   logic [3:0]  alpha_val;
   logic        fifo_full;
   logic [81:0] fifo_wdata;
   logic        fifo_wenable;

   modport master (
      output cmd_valid, inst_type, vertice_num, coordinates, layer_num,
             fill_type, color_code, texture_code, alpha_val, fifo_full,
      input  cmd_ready, fifo_wdata, fifo_wenable
   );

   modport slave (
      input  cmd_valid, inst_type, vertice_num, coordinates, layer_num,
             fill_type, color_code, texture_code, alpha_val, fifo_full,
      output cmd_ready, fifo_wdata, fifo_wenable
   );
endinterface

// File: rtl/instruction_encoder.sv
// Packs draw/alpha commands into 82-bit words; one-cycle latency, one word per cycle.
// A single holding register stalls on fifo_full, which deasserts cmd_ready while a word waits.
module instruction_encoder (
   input  logic                  clk,
   input  logic                  n_rst,
   instruction_encoder_if.slave  bus,
   output logic                  busy,
   output logic [15:0]           word_count
);

   typedef struct packed {
      logic [3:0]  alpha;
      logic [1:0]  texture;
      logic [23:0] color;
      logic        fill;
      logic        layer;
      logic [15:0] v2;
      logic [15:0] v1;
      logic [15:0] v0;
      logic        vnum;
      logic        itype;
   } inst_word_t;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t     state;
   inst_word_t held;
   inst_word_t packed_cmd;
   logic       accept;
   logic       write;

   always_comb begin
      packed_cmd       = '0;
      packed_cmd.itype = bus.inst_type;
      packed_cmd.alpha = bus.alpha_val;
      // Alpha-only words carry nothing but the type bit and alpha.
      if (!bus.inst_type) begin
         packed_cmd.vnum  = bus.vertice_num;
         packed_cmd.v0    = bus.coordinates[15:0];
         packed_cmd.v1    = bus.coordinates[31:16];
         packed_cmd.v2    = bus.vertice_num ? bus.coordinates[47:32] : 16'd0;
         packed_cmd.layer = bus.layer_num;
         packed_cmd.fill  = bus.fill_type;
         if (bus.fill_type)
            packed_cmd.texture = bus.texture_code;
         else
            packed_cmd.color = bus.color_code;
      end
   end

   assign write            = (state == HOLD) && !bus.fifo_full;
   assign bus.cmd_ready    = (state == IDLE) || write;
   assign accept           = bus.cmd_valid && bus.cmd_ready;
   assign bus.fifo_wenable = write;
   assign bus.fifo_wdata   = held;
   assign busy             = (state == HOLD);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         held       <= '0;
         word_count <= 16'd0;
      end else begin
         if (write)
            word_count <= word_count + 16'd1;
         case (state)
            IDLE: begin
               if (accept) begin
                  held  <= packed_cmd;
                  state <= HOLD;
               end
            end
            HOLD: begin
               // Draining and refilling on the same edge keeps full throughput.
               if (accept)
                  held <= packed_cmd;
               else if (write)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL have a single clock, clk (input, 1 bit); all state is updated on its rising edge.
REQ-002 The block SHALL have reset n_rst (input, 1 bit), asynchronous and active-low.
REQ-003 cmd_valid (input, 1 bit) SHALL mean the command fields below are valid this cycle.
REQ-004 cmd_ready (output, 1 bit) SHALL mean the block accepts a command this cycle; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-005 inst_type (input, 1 bit) SHALL select the instruction type: 0 = draw, 1 = alpha-only.
REQ-006 vertice_num (input, 1 bit) SHALL select the vertex count: 0 = 2 vertices, 1 = 3 vertices.
REQ-007 coordinates (input, 48 bits) SHALL carry the vertices: [15:0] = v0, [31:16] = v1, [47:32] = v2.
REQ-008 The remaining command fields SHALL be:
- layer_num (input, 1 bit): layer select.
- fill_type (input, 1 bit): 0 = solid colour, 1 = texture.
- color_code (input, 24 bits): fill colour.
- texture_code (input, 2 bits): texture select.
- alpha_val (input, 4 bits): alpha value.
REQ-009 fifo_full (input, 1 bit) SHALL mean the downstream instruction FIFO cannot accept a write this cycle.
REQ-010 fifo_wdata (output, 82 bits) SHALL carry the packed instruction word to the FIFO.
REQ-011 fifo_wenable (output, 1 bit) SHALL be the FIFO write strobe; each cycle it is 1 writes exactly one word.
REQ-012 busy (output, 1 bit) SHALL be 1 whenever a packed word is held and not yet written.
REQ-013 word_count (output, 16 bits) SHALL be the number of words written since reset.

Function
REQ-014 The block SHALL implement a two-state FSM:
- IDLE: no word held.
- HOLD: one packed word is registered on fifo_wdata.
REQ-015 Packing SHALL set bit [0] = inst_type and bits [81:78] = alpha_val for both instruction types.
REQ-016 For inst_type=0, packing SHALL set:
- [1] = vertice_num
- [17:2] = coordinates[15:0]
- [33:18] = coordinates[31:16]
- [49:34] = coordinates[47:32] if vertice_num=1, else 0
- [50] = layer_num
- [51] = fill_type
REQ-017 For inst_type=0, the fill fields SHALL be mutually exclusive:
- fill_type=0: [75:52] = color_code and [77:76] = 0.
- fill_type=1: [75:52] = 0 and [77:76] = texture_code.
REQ-018 For inst_type=1, packing SHALL force bits [77:1] to 0, ignoring all other inputs.
REQ-019 fifo_wenable SHALL equal (state==HOLD && !fifo_full), combinationally.
REQ-020 cmd_ready SHALL equal (state==IDLE) || (state==HOLD && !fifo_full).
REQ-021 In IDLE, an accepted command SHALL register its packed word into fifo_wdata and move the FSM to HOLD on the same edge.
REQ-022 In HOLD with fifo_full=1, the FSM SHALL stay in HOLD with fifo_wdata stable and no command accepted.
REQ-023 In HOLD with fifo_full=0 and an accepted command, the held word SHALL be written and the new packed word SHALL load on the same edge, staying in HOLD (throughput one word per cycle).
REQ-024 In HOLD with fifo_full=0 and cmd_valid=0, the word SHALL be written and the FSM SHALL return to IDLE.
REQ-025 Latency SHALL be one cycle: a command accepted at edge N drives fifo_wenable in cycle N+1 if fifo_full=0.
REQ-026 word_count SHALL increment by 1 on each edge where fifo_wenable=1 and SHALL wrap from 0xFFFF to 0x0000.
REQ-027 busy SHALL equal (state==HOLD).
REQ-028 fifo_wdata SHALL hold its last value in IDLE.
REQ-029 Command inputs SHALL be sampled only on acceptance, so input changes while cmd_ready=0 have no effect.

Reset
REQ-030 While n_rst=0, the block SHALL be in IDLE with fifo_wdata=0, word_count=0, busy=0, fifo_wenable=0 and cmd_ready=1.
REQ-031 Reset asserted in HOLD SHALL discard the held word without writing it.
REQ-032 After n_rst deasserts, the first edge SHALL accept a command normally.

Verification
REQ-033 Draw, 3 vertices, solid fill: inst_type=0, vertice_num=1, coordinates=0x000300020001, layer_num=1, fill_type=0, color_code=0xFF0000, alpha_val=0xA, with fifo_full=0 -> one fifo_wenable pulse next cycle; fifo_wdata has [49:34]=3, [33:18]=2, [17:2]=1, [50]=1, [75:52]=0xFF0000, [77:76]=0, [81:78]=0xA; word_count=1.
REQ-034 Draw, 2 vertices, texture fill: vertice_num=0, coordinates=0xFFFF00050004, fill_type=1, texture_code=2'b10, color_code=0x123456 -> [49:34]=0, [77:76]=2, [75:52]=0.
REQ-035 Alpha-only: inst_type=1, alpha_val=0x5, all other fields all-ones -> fifo_wdata = 0x5 in [81:78], 1 in [0], all other bits 0.
REQ-036 fifo_full held at 1 for 5 cycles after an accept -> fifo_wdata stable, cmd_ready=0, busy=1, no write; fifo_full then 0 -> exactly one write.
REQ-037 cmd_valid=1 for 10 consecutive distinct commands with fifo_full=0 -> 10 writes on consecutive cycles, in order, with word_count=10.
REQ-038 n_rst pulsed low in HOLD with fifo_full=1 -> immediate IDLE, word_count=0, and no write of the held word.
